scr1_ahb_mem_arb: RTL and testbench

//  Shares one AHB-Lite slave (on-chip TCM/SRAM in the system block) between the SCR1 imem
//  (read-only) and dmem (R/W) master ports. Masters issue SINGLE transfers only.

---
 rtl/scr1_ahb_arb_pkg.sv | 21 ++
 rtl/scr1_ahb_req_hold.sv | 27 ++
 rtl/scr1_ahb_mem_arb.sv | 123 ++++++++++++
 tb/tb_scr1_ahb_mem_arb.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scr1_ahb_arb_pkg.sv
// Shared types for the SCR1 imem/dmem AHB-Lite memory arbiter.
package scr1_ahb_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam int         ARB_AW_MAX    = 32;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_IMEM = 2'd1,
        OWNER_DMEM = 2'd2
    } type_scr1_arb_owner_e;

    typedef struct packed {
        logic [ARB_AW_MAX-1:0] addr;
        logic [2:0]            size;
        logic [3:0]            prot;
        logic                  write;
    } type_scr1_ahb_req_s;

endpackage

// File: rtl/scr1_ahb_req_hold.sv
// One-deep capture register for an address phase that could not be forwarded at once.
module scr1_ahb_req_hold
    import scr1_ahb_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               capture,
    input  logic               clear,
    input  type_scr1_ahb_req_s live,
    output logic               pend,
    output type_scr1_ahb_req_s held
);

    // capture and clear never coincide: a live request implies pend = 0
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
            held <= '0;
        end else if (capture) begin
            pend <= 1'b1;
            held <= live;
        end else if (clear) begin
            pend <= 1'b0;
        end
    end

endmodule

// File: rtl/scr1_ahb_mem_arb.sv
// Arbitrates the SCR1 imem and dmem AHB-Lite masters onto one memory slave,
// holding the losing address phase and routing each data phase back to its owner.
module scr1_ahb_mem_arb
    import scr1_ahb_arb_pkg::*;
#(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter bit ARB_RR = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    imem_htrans,
    input  logic [AW-1:0] imem_haddr,
    input  logic [2:0]    imem_hsize,
    input  logic [3:0]    imem_hprot,
    output logic          imem_hready,
    output logic [DW-1:0] imem_hrdata,
    output logic          imem_hresp,
    input  logic [1:0]    dmem_htrans,
    input  logic [AW-1:0] dmem_haddr,
    input  logic [2:0]    dmem_hsize,
    input  logic [3:0]    dmem_hprot,
    input  logic          dmem_hwrite,
    input  logic [DW-1:0] dmem_hwdata,
    output logic          dmem_hready,
    output logic [DW-1:0] dmem_hrdata,
    output logic          dmem_hresp,
    output logic [1:0]    s_htrans,
    output logic [AW-1:0] s_haddr,
    output logic [2:0]    s_hsize,
    output logic [3:0]    s_hprot,
    output logic          s_hwrite,
    output logic [DW-1:0] s_hwdata,
    input  logic          s_hready,
    input  logic [DW-1:0] s_hrdata,
    input  logic          s_hresp
);

    type_scr1_arb_owner_e owner, last, grant;
    type_scr1_ahb_req_s   live_i, live_d, held_i, held_d, sel, addr_q;
    logic                 pend_i, pend_d;
    logic                 live_req_i, live_req_d, req_i, req_d;

    always_comb begin
        imem_hready = (owner == OWNER_IMEM) ? s_hready : !pend_i;
        dmem_hready = (owner == OWNER_DMEM) ? s_hready : !pend_d;
        live_i      = '{addr: ARB_AW_MAX'(imem_haddr), size: imem_hsize, prot: imem_hprot, write: 1'b0};
        live_d      = '{addr: ARB_AW_MAX'(dmem_haddr), size: dmem_hsize, prot: dmem_hprot, write: dmem_hwrite};
        live_req_i  = imem_hready && (imem_htrans == HTRANS_NONSEQ);
        live_req_d  = dmem_hready && (dmem_htrans == HTRANS_NONSEQ);
        req_i       = pend_i || live_req_i;
        req_d       = pend_d || live_req_d;
    end

    always_comb begin
        grant = OWNER_NONE;
        if (s_hready) begin
            if (req_i && req_d)
                grant = (ARB_RR && last == OWNER_DMEM) ? OWNER_IMEM : OWNER_DMEM;
            else if (req_d)
                grant = OWNER_DMEM;
            else if (req_i)
                grant = OWNER_IMEM;
        end
    end

    // While the slave stalls, the last forwarded address stays on the bus
    always_comb begin
        case (grant)
            OWNER_IMEM: sel = pend_i ? held_i : live_i;
            OWNER_DMEM: sel = pend_d ? held_d : live_d;
            default:    sel = addr_q;
        endcase
        s_htrans = (grant != OWNER_NONE) ? HTRANS_NONSEQ : HTRANS_IDLE;
        s_haddr  = AW'(sel.addr);
        s_hsize  = sel.size;
        s_hprot  = sel.prot;
        s_hwrite = sel.write;
    end

    always_comb begin
        s_hwdata    = (owner == OWNER_DMEM) ? dmem_hwdata : '0;
        imem_hrdata = s_hrdata;
        dmem_hrdata = s_hrdata;
        imem_hresp  = (owner == OWNER_IMEM) && s_hresp;
        dmem_hresp  = (owner == OWNER_DMEM) && s_hresp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner  <= OWNER_NONE;
            last   <= OWNER_IMEM;
            addr_q <= '0;
        end else if (s_hready) begin
            owner <= grant;
            if (grant != OWNER_NONE) begin
                last   <= grant;
                addr_q <= sel;
            end
        end
    end

    scr1_ahb_req_hold u_hold_imem (
        .clk     (clk),
        .rst     (rst),
        .capture (live_req_i && (grant != OWNER_IMEM)),
        .clear   (grant == OWNER_IMEM),
        .live    (live_i),
        .pend    (pend_i),
        .held    (held_i)
    );

    scr1_ahb_req_hold u_hold_dmem (
        .clk     (clk),
        .rst     (rst),
        .capture (live_req_d && (grant != OWNER_DMEM)),
        .clear   (grant == OWNER_DMEM),
        .live    (live_d),
        .pend    (pend_d),
        .held    (held_d)
    );

endmodule

// File: tb/tb_scr1_ahb_mem_arb.sv
// Scoreboard bench: expected slave address phases are queued as stimulus is driven
// and retired by a monitor that also checks the returning data phase.
module tb_scr1_ahb_mem_arb;
    import scr1_ahb_arb_pkg::*;

    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] ID = 2'b00;
    localparam logic [31:0] RD_KEY = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  imem_htrans = ID, dmem_htrans = ID;
    logic [31:0] imem_haddr = '0, dmem_haddr = '0;
    logic [2:0]  imem_hsize = 3'b010, dmem_hsize = 3'b010;
    logic [3:0]  imem_hprot = 4'b0010, dmem_hprot = 4'b0011;
    logic        dmem_hwrite = 1'b0;
    logic [31:0] dmem_hwdata = '0;
    logic        imem_hready, dmem_hready, imem_hresp, dmem_hresp;
    logic [31:0] imem_hrdata, dmem_hrdata;
    logic [1:0]  s_htrans;
    logic [31:0] s_haddr, s_hwdata, s_hrdata;
    logic [2:0]  s_hsize;
    logic [3:0]  s_hprot;
    logic        s_hwrite;
    logic        s_hready = 1'b1, s_hresp = 1'b0;
    logic [31:0] slv_addr;

    typedef struct {
        bit          is_d;
        logic [31:0] addr;
        bit          write;
        logic [31:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0, n_total = 0;

    always #5 clk = ~clk;

    // Slave model: read data is derived from the address it accepted
    always @(posedge clk)
        if (rst) slv_addr <= '0;
        else if (s_hready && s_htrans == NS) slv_addr <= s_haddr;
    assign s_hrdata = slv_addr ^ RD_KEY;

    scr1_ahb_mem_arb #(.AW(32), .DW(32), .ARB_RR(1'b1)) dut (
        .clk(clk), .rst(rst),
        .imem_htrans(imem_htrans), .imem_haddr(imem_haddr), .imem_hsize(imem_hsize),
        .imem_hprot(imem_hprot), .imem_hready(imem_hready), .imem_hrdata(imem_hrdata),
        .imem_hresp(imem_hresp),
        .dmem_htrans(dmem_htrans), .dmem_haddr(dmem_haddr), .dmem_hsize(dmem_hsize),
        .dmem_hprot(dmem_hprot), .dmem_hwrite(dmem_hwrite), .dmem_hwdata(dmem_hwdata),
        .dmem_hready(dmem_hready), .dmem_hrdata(dmem_hrdata), .dmem_hresp(dmem_hresp),
        .s_htrans(s_htrans), .s_haddr(s_haddr), .s_hsize(s_hsize), .s_hprot(s_hprot),
        .s_hwrite(s_hwrite), .s_hwdata(s_hwdata),
        .s_hready(s_hready), .s_hrdata(s_hrdata), .s_hresp(s_hresp)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        imem_htrans = ID;
        dmem_htrans = ID;
        dmem_hwrite = 1'b0;
        s_hready    = 1'b1;
        s_hresp     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_all();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic monitor();
        exp_t        e, dp;
        bit          dp_v = 1'b0;
        logic [31:0] ew;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                dp_v = 1'b0;
            end else begin
                if (dp_v) begin
                    ew = dp.is_d ? dp.wdata : 32'h0;
                    n_total++;
                    if (s_hwdata !== ew) $display("FAIL dp_hwdata addr=%h got %h exp %h", dp.addr, s_hwdata, ew);
                    else n_pass++;
                    if (s_hready && !s_hresp) begin
                        n_total++;
                        if ((dp.is_d ? dmem_hready : imem_hready) !== 1'b1 ||
                            (dp.is_d ? dmem_hrdata : imem_hrdata) !== (dp.addr ^ RD_KEY))
                            $display("FAIL dp_rdata addr=%h d=%0d got rdy %b/%b data %h/%h exp %h",
                                     dp.addr, dp.is_d, imem_hready, dmem_hready, imem_hrdata, dmem_hrdata, dp.addr ^ RD_KEY);
                        else n_pass++;
                    end
                end
                if (s_hready) dp_v = 1'b0;
                if (s_hready && s_htrans == NS) begin
                    n_total++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL grant_unexpected got addr %h exp none", s_haddr);
                    end else begin
                        e = exp_q.pop_front();
                        if (s_haddr !== e.addr || s_hwrite !== e.write)
                            $display("FAIL grant_order got %h/w%b exp %h/w%b", s_haddr, s_hwrite, e.addr, e.write);
                        else n_pass++;
                        dp   = e;
                        dp_v = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_all();
        cyc();
        cyc();
        #2;
        n_total++; if (s_htrans !== ID) $display("FAIL reset_htrans got %b exp %b", s_htrans, ID); else n_pass++;
        n_total++; if (imem_hready !== 1'b1) $display("FAIL reset_imem_hready got %b exp 1", imem_hready); else n_pass++;
        n_total++; if (dmem_hready !== 1'b1) $display("FAIL reset_dmem_hready got %b exp 1", dmem_hready); else n_pass++;
        n_total++; if ({imem_hresp, dmem_hresp} !== 2'b00) $display("FAIL reset_hresp got %b exp 00", {imem_hresp, dmem_hresp}); else n_pass++;
        n_total++; if (imem_hrdata !== RD_KEY) $display("FAIL reset_hrdata got %h exp %h", imem_hrdata, RD_KEY); else n_pass++;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_imem_single();
        exp_q.push_back('{is_d: 1'b0, addr: 32'h100, write: 1'b0, wdata: 32'h0});
        imem_htrans = NS;
        imem_haddr  = 32'h100;
        #2;
        n_total++; if (s_htrans !== NS || s_haddr !== 32'h100) $display("FAIL single_addr got %b/%h exp %b/%h", s_htrans, s_haddr, NS, 32'h100); else n_pass++;
        n_total++; if (s_hsize !== 3'b010 || s_hprot !== 4'b0010) $display("FAIL single_ctrl got %b/%b exp 010/0010", s_hsize, s_hprot); else n_pass++;
        n_total++; if (imem_hready !== 1'b1) $display("FAIL single_hready_a got %b exp 1", imem_hready); else n_pass++;
        cyc();
        imem_htrans = ID;
        #2;
        n_total++; if (imem_hready !== 1'b1) $display("FAIL single_hready_d got %b exp 1", imem_hready); else n_pass++;
        cyc();
        #2;
        n_total++; if (exp_q.size() != 0) $display("FAIL single_drain got %0d exp 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_tie_rr();
        do_reset();
        exp_q.push_back('{is_d: 1'b1, addr: 32'h2000, write: 1'b1, wdata: 32'hDEAD_BEEF});
        exp_q.push_back('{is_d: 1'b0, addr: 32'h100, write: 1'b0, wdata: 32'h0});
        imem_htrans = NS; imem_haddr = 32'h100;
        dmem_htrans = NS; dmem_haddr = 32'h2000; dmem_hwrite = 1'b1; dmem_hwdata = 32'hDEAD_BEEF;
        #2;
        n_total++; if (s_haddr !== 32'h2000 || s_hwrite !== 1'b1) $display("FAIL tie_first got %h/w%b exp 2000/w1", s_haddr, s_hwrite); else n_pass++;
        cyc();
        imem_htrans = ID; dmem_htrans = ID; dmem_hwrite = 1'b0;
        #2;
        n_total++; if (imem_hready !== 1'b0) $display("FAIL tie_imem_held got %b exp 0", imem_hready); else n_pass++;
        n_total++; if (s_htrans !== NS || s_haddr !== 32'h100 || s_hwrite !== 1'b0) $display("FAIL tie_second got %b/%h/w%b exp %b/100/w0", s_htrans, s_haddr, s_hwrite, NS); else n_pass++;
        n_total++; if (s_hwdata !== 32'hDEAD_BEEF) $display("FAIL tie_hwdata got %h exp deadbeef", s_hwdata); else n_pass++;
        cyc();
        #2;
        n_total++; if (imem_hready !== 1'b1 || s_hwdata !== 32'h0) $display("FAIL tie_imem_done got %b/%h exp 1/0", imem_hready, s_hwdata); else n_pass++;
        cyc();
        n_total++; if (exp_q.size() != 0) $display("FAIL tie_drain got %0d exp 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_rr_alternate();
        logic [31:0] ia [3];
        logic [31:0] da [3];
        int ii = 0, di = 0;
        ia = '{32'h200, 32'h204, 32'h208};
        da = '{32'h3000, 32'h3004, 32'h3008};
        do_reset();
        dmem_hwdata = 32'h0BAD_F00D;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back('{is_d: 1'b1, addr: da[k], write: 1'b0, wdata: 32'h0BAD_F00D});
            exp_q.push_back('{is_d: 1'b0, addr: ia[k], write: 1'b0, wdata: 32'h0});
        end
        for (int c = 0; c < 12; c++) begin
            imem_htrans = (ii < 3) ? NS : ID;
            imem_haddr  = ia[(ii < 3) ? ii : 2];
            dmem_htrans = (di < 3) ? NS : ID;
            dmem_haddr  = da[(di < 3) ? di : 2];
            #2;
            if (ii < 3 && imem_hready) ii++;
            if (di < 3 && dmem_hready) di++;
            cyc();
        end
        n_total++; if (ii != 3 || di != 3) $display("FAIL rr_accepts got %0d/%0d exp 3/3", ii, di); else n_pass++;
        n_total++; if (exp_q.size() != 0) $display("FAIL rr_drain got %0d exp 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_wait_states();
        do_reset();
        dmem_hwdata = 32'h4444_0000;
        exp_q.push_back('{is_d: 1'b1, addr: 32'h4000, write: 1'b0, wdata: 32'h4444_0000});
        exp_q.push_back('{is_d: 1'b0, addr: 32'h104, write: 1'b0, wdata: 32'h0});
        dmem_htrans = NS; dmem_haddr = 32'h4000;
        cyc();
        dmem_htrans = ID;
        imem_htrans = NS; imem_haddr = 32'h104;
        s_hready = 1'b0;
        #2;
        n_total++; if (imem_hready !== 1'b1) $display("FAIL ws_imem_accept got %b exp 1", imem_hready); else n_pass++;
        for (int w = 0; w < 3; w++) begin
            n_total++; if (s_haddr !== 32'h4000 || s_htrans !== ID) $display("FAIL ws_hold%0d got %h/%b exp 4000/%b", w, s_haddr, s_htrans, ID); else n_pass++;
            n_total++; if (dmem_hready !== 1'b0) $display("FAIL ws_dmem_wait%0d got %b exp 0", w, dmem_hready); else n_pass++;
            cyc();
            imem_htrans = ID;
            #2;
            if (w < 2) begin
                n_total++; if (imem_hready !== 1'b0) $display("FAIL ws_imem_held%0d got %b exp 0", w, imem_hready); else n_pass++;
            end
        end
        s_hready = 1'b1;
        #1;
        n_total++; if (s_htrans !== NS || s_haddr !== 32'h104) $display("FAIL ws_release got %b/%h exp %b/104", s_htrans, s_haddr, NS); else n_pass++;
        n_total++; if (dmem_hready !== 1'b1) $display("FAIL ws_dmem_done got %b exp 1", dmem_hready); else n_pass++;
        cyc();
        cyc();
        n_total++; if (exp_q.size() != 0) $display("FAIL ws_drain got %0d exp 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_error();
        do_reset();
        exp_q.push_back('{is_d: 1'b1, addr: 32'h5000, write: 1'b1, wdata: 32'h0000_1234});
        exp_q.push_back('{is_d: 1'b0, addr: 32'h108, write: 1'b0, wdata: 32'h0});
        dmem_htrans = NS; dmem_haddr = 32'h5000; dmem_hwrite = 1'b1; dmem_hwdata = 32'h0000_1234;
        cyc();
        dmem_htrans = ID; dmem_hwrite = 1'b0;
        imem_htrans = NS; imem_haddr = 32'h108;
        s_hready = 1'b0; s_hresp = 1'b1;
        #2;
        n_total++; if (dmem_hresp !== 1'b1 || dmem_hready !== 1'b0) $display("FAIL err_c1_dmem got %b/%b exp 1/0", dmem_hresp, dmem_hready); else n_pass++;
        n_total++; if (imem_hresp !== 1'b0) $display("FAIL err_c1_imem_hresp got %b exp 0", imem_hresp); else n_pass++;
        cyc();
        imem_htrans = ID;
        s_hready = 1'b1;
        #2;
        n_total++; if (dmem_hresp !== 1'b1 || dmem_hready !== 1'b1) $display("FAIL err_c2_dmem got %b/%b exp 1/1", dmem_hresp, dmem_hready); else n_pass++;
        n_total++; if (imem_hresp !== 1'b0 || imem_hready !== 1'b0) $display("FAIL err_c2_imem got %b/%b exp 0/0", imem_hresp, imem_hready); else n_pass++;
        n_total++; if (s_htrans !== NS || s_haddr !== 32'h108) $display("FAIL err_held_issue got %b/%h exp %b/108", s_htrans, s_haddr, NS); else n_pass++;
        cyc();
        s_hresp = 1'b0;
        #2;
        n_total++; if (imem_hresp !== 1'b0 || imem_hready !== 1'b1 || dmem_hresp !== 1'b0) $display("FAIL err_c3 got %b/%b/%b exp 0/1/0", imem_hresp, imem_hready, dmem_hresp); else n_pass++;
        cyc();
        n_total++; if (exp_q.size() != 0) $display("FAIL err_drain got %0d exp 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_reset_mid();
        // last grant was imem, so dmem takes this tie and imem is left pending
        exp_q.push_back('{is_d: 1'b1, addr: 32'h6000, write: 1'b0, wdata: 32'h0});
        imem_htrans = NS; imem_haddr = 32'h10C;
        dmem_htrans = NS; dmem_haddr = 32'h6000; dmem_hwdata = 32'h0;
        #2;
        n_total++; if (s_haddr !== 32'h6000) $display("FAIL rmid_first got %h exp 6000", s_haddr); else n_pass++;
        cyc();
        rst = 1'b1;
        imem_htrans = ID; dmem_htrans = ID;
        #2;
        n_total++; if (imem_hready !== 1'b0) $display("FAIL rmid_pend got %b exp 0", imem_hready); else n_pass++;
        cyc();
        rst = 1'b0;
        #2;
        n_total++; if (s_htrans !== ID) $display("FAIL rmid_htrans got %b exp %b", s_htrans, ID); else n_pass++;
        n_total++; if (imem_hready !== 1'b1 || dmem_hready !== 1'b1) $display("FAIL rmid_hready got %b/%b exp 1/1", imem_hready, dmem_hready); else n_pass++;
        n_total++; if (s_hwdata !== 32'h0 || {imem_hresp, dmem_hresp} !== 2'b00) $display("FAIL rmid_dp got %h/%b exp 0/00", s_hwdata, {imem_hresp, dmem_hresp}); else n_pass++;
        cyc();
        #2;
        n_total++; if (s_htrans !== ID) $display("FAIL rmid_no_replay got %b exp %b", s_htrans, ID); else n_pass++;
        n_total++; if (exp_q.size() != 0) $display("FAIL rmid_drain got %0d exp 0", exp_q.size()); else n_pass++;
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_imem_single();
        test_tie_rr();
        test_rr_alternate();
        test_wait_states();
        test_error();
        test_reset_mid();
        cyc();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
